// File: rtl/pixel_addr_pkg.sv
// Shared screen constants, scale helper and row-tracker state type for the
// frame-buffer address generator.
package pixel_addr_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } state_e;

  // Shift amount for a power-of-two replication factor (1, 2 or 4).
  function automatic int unsigned log2_scale(input int unsigned scale);
    if (scale == 4) return 2;
    if (scale == 2) return 1;
    return 0;
  endfunction

endpackage

// File: rtl/region_address_gen_if.sv
// Scan-coordinate in / buffer-address out bundle of the region address generator.
interface region_address_gen_if #(
  parameter int unsigned AW = 32
);
  logic                                 pixel_en;
  logic [pixel_addr_pkg::COORD_W-1:0]   x_pixel;
  logic [pixel_addr_pkg::COORD_W-1:0]   y_pixel;
  logic [AW-1:0]                        address;
  logic                                 addr_valid;
  logic                                 in_region;
  logic                                 frame_done;

  modport master (
    output pixel_en, x_pixel, y_pixel,
    input  address, addr_valid, in_region, frame_done
  );

  modport slave (
    input  pixel_en, x_pixel, y_pixel,
    output address, addr_valid, in_region, frame_done
  );
endinterface

// File: rtl/region_row_tracker.sv
// Tracks the frame-buffer row base address and the armed/region state,
// advancing only on the first pixel tick of each line.
module region_row_tracker
  import pixel_addr_pkg::*;
#(
  parameter int unsigned Y0     = 80,
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 320,
  parameter int unsigned SCALE  = 1,
  parameter int unsigned BASE   = 212992,
  parameter int unsigned AW     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixel_en_i,
  input  logic [COORD_W-1:0] x_pixel_i,
  input  logic [COORD_W-1:0] y_pixel_i,
  output logic [AW-1:0]      row_base_c_o,
  output logic               armed_c_o
);

  localparam int unsigned Y_END   = Y0 + HEIGHT * SCALE;
  localparam int unsigned ROW_MSK = SCALE - 1;
  localparam logic [AW-1:0] BASE_A  = AW'(BASE);
  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  state_e        state_q, state_d;
  logic [AW-1:0] row_base_q, row_base_d;

  logic line_start_c;
  logic y_first_c;
  logic y_in_c;
  logic row_step_c;

  assign line_start_c = pixel_en_i && (x_pixel_i == '0);
  assign y_first_c    = (32'(y_pixel_i) == Y0);
  assign y_in_c       = (32'(y_pixel_i) >= Y0) && (32'(y_pixel_i) < Y_END);
  // A new source row starts every SCALE screen lines after the first.
  assign row_step_c   = y_in_c && (32'(y_pixel_i) > Y0) &&
                        (((32'(y_pixel_i) - Y0) & ROW_MSK) == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_base_q <= BASE_A;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    if (line_start_c) begin
      if (y_first_c) begin
        row_base_d = BASE_A;
      end else if (row_step_c) begin
        row_base_d = row_base_q + WIDTH_A;
      end
      unique case (state_q)
        IDLE:          if (y_first_c) state_d = ACTIVE;
        ACTIVE, BLANK: state_d = y_in_c ? ACTIVE : BLANK;
        default:       state_d = IDLE;
      endcase
    end
  end

  // Next-state values are exported so the line-start tick already sees them.
  assign row_base_c_o = row_base_d;
  assign armed_c_o    = (state_d != IDLE);

endmodule

// File: rtl/region_address_gen.sv
// Pipelined frame-buffer read-address generator for a scaled display region,
// issuing each address LAT pixel ticks ahead of the scan position.
module region_address_gen
  import pixel_addr_pkg::*;
#(
  parameter int unsigned X0     = 160,
  parameter int unsigned Y0     = 80,
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 320,
  parameter int unsigned SCALE  = 1,
  parameter int unsigned BASE   = 212992,
  parameter int unsigned AW     = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  region_address_gen_if.slave bus
);

  localparam int unsigned SHIFT = log2_scale(SCALE);
  localparam int unsigned X_END = X0 + WIDTH * SCALE;
  localparam int unsigned Y_END = Y0 + HEIGHT * SCALE;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
    $error("region_address_gen: SCALE must be 1, 2 or 4");
  end
  if (LAT < 1 || LAT > 4 || X0 < LAT) begin : g_bad_lat
    $error("region_address_gen: LAT must be 1..4 and not exceed X0");
  end
  if (X_END > H_ACTIVE || Y_END > V_ACTIVE) begin : g_bad_region
    $error("region_address_gen: region does not fit on the 640x480 screen");
  end

  logic [AW-1:0]      row_base_c;
  logic               armed_c;
  logic [COORD_W:0]   xl_c;
  logic               x_look_in_c, x_cur_in_c, y_in_c;
  logic               valid_c, last_c;
  logic [AW-1:0]      col_c, addr_c;

  logic [AW-1:0]      address_q;
  logic               addr_valid_q, in_region_q, frame_done_q;

  region_row_tracker #(
    .Y0     (Y0),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .SCALE  (SCALE),
    .BASE   (BASE),
    .AW     (AW)
  ) u_row_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_en_i   (bus.pixel_en),
    .x_pixel_i    (bus.x_pixel),
    .y_pixel_i    (bus.y_pixel),
    .row_base_c_o (row_base_c),
    .armed_c_o    (armed_c)
  );

  // Lookahead column is one bit wider so it cannot wrap back into the region.
  assign xl_c        = {1'b0, bus.x_pixel} + (COORD_W + 1)'(LAT);
  assign x_look_in_c = (32'(xl_c) >= X0) && (32'(xl_c) < X_END);
  assign x_cur_in_c  = (32'(bus.x_pixel) >= X0) && (32'(bus.x_pixel) < X_END);
  assign y_in_c      = (32'(bus.y_pixel) >= Y0) && (32'(bus.y_pixel) < Y_END);

  assign valid_c = armed_c && x_look_in_c && y_in_c;
  assign col_c   = AW'((32'(xl_c) - X0) >> SHIFT);
  assign addr_c  = valid_c ? (row_base_c + col_c) : BASE_A;
  assign last_c  = valid_c && (32'(xl_c) == X_END - 1) && (32'(bus.y_pixel) == Y_END - 1);

  // frame_done self-clears on the next clk so it is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q    <= '0;
      addr_valid_q <= 1'b0;
      in_region_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= bus.pixel_en && last_c;
      if (bus.pixel_en) begin
        address_q    <= addr_c;
        addr_valid_q <= valid_c;
        in_region_q  <= armed_c && x_cur_in_c && y_in_c;
      end
    end
  end

  assign bus.address    = address_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.in_region  = in_region_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_region_address_gen.sv
// Bench for region_address_gen: default and 2x-scaled instances against an
// arithmetic model, plus hand-computed spot values.
module tb_region_address_gen;

  localparam int unsigned AW = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pixel_en;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;

  int errors = 0;
  int checks = 0;

  region_address_gen_if #(.AW(AW)) bus0 ();
  region_address_gen_if #(.AW(AW)) bus1 ();

  assign bus0.pixel_en = pixel_en;
  assign bus0.x_pixel  = x_pixel;
  assign bus0.y_pixel  = y_pixel;
  assign bus1.pixel_en = pixel_en;
  assign bus1.x_pixel  = x_pixel;
  assign bus1.y_pixel  = y_pixel;

  region_address_gen u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  region_address_gen #(
    .X0     (4),
    .Y0     (0),
    .WIDTH  (318),
    .HEIGHT (240),
    .SCALE  (2)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic        inreg;
    logic        fd;
  } exp_t;

  // Expected outputs straight from the region/scale arithmetic.
  function automatic exp_t model(input int x0, input int y0, input int w, input int h,
                                 input int s, input int base, input int lat,
                                 input bit armed, input int x, input int y);
    exp_t r;
    int   xl;
    bit   yin, xin_l, xin;
    xl      = x + lat;
    yin     = (y >= y0) && (y < y0 + h * s);
    xin_l   = (xl >= x0) && (xl < x0 + w * s);
    xin     = (x >= x0) && (x < x0 + w * s);
    r.valid = armed && xin_l && yin;
    r.inreg = armed && xin && yin;
    r.addr  = r.valid ? 32'(base + ((y - y0) / s) * w + (xl - x0) / s) : 32'(base);
    r.fd    = r.valid && (xl == x0 + w * s - 1) && (y == y0 + h * s - 1);
    return r;
  endfunction

  bit   arm0, arm1;
  exp_t e0, e1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm0 <= 1'b0;
      arm1 <= 1'b0;
      e0   <= '0;
      e1   <= '0;
    end else begin
      e0.fd <= 1'b0;
      e1.fd <= 1'b0;
      if (pixel_en) begin
        arm0 <= arm0 || (x_pixel == 0 && y_pixel == 80);
        arm1 <= arm1 || (x_pixel == 0 && y_pixel == 0);
        e0 <= model(160, 80, 320, 320, 1, 212992, 1,
                    arm0 || (x_pixel == 0 && y_pixel == 80), int'(x_pixel), int'(y_pixel));
        e1 <= model(4, 0, 318, 240, 2, 212992, 1,
                    arm1 || (x_pixel == 0 && y_pixel == 0), int'(x_pixel), int'(y_pixel));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)",
               name, act, exp, x_pixel, y_pixel, $time);
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dut0.address",    bus0.address,    e0.addr);
      chk("dut0.addr_valid", 32'(bus0.addr_valid), 32'(e0.valid));
      chk("dut0.in_region",  32'(bus0.in_region),  32'(e0.inreg));
      chk("dut0.frame_done", 32'(bus0.frame_done), 32'(e0.fd));
      chk("dut1.address",    bus1.address,    e1.addr);
      chk("dut1.addr_valid", 32'(bus1.addr_valid), 32'(e1.valid));
      chk("dut1.in_region",  32'(bus1.in_region),  32'(e1.inreg));
      chk("dut1.frame_done", 32'(bus1.frame_done), 32'(e1.fd));
    end
  end

  task automatic tick(input int xv, input int yv);
    x_pixel  = 10'(xv);
    y_pixel  = 10'(yv);
    pixel_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".dut0.address"},    bus0.address, 32'd0);
    chk({tag, ".dut0.addr_valid"}, 32'(bus0.addr_valid), 32'd0);
    chk({tag, ".dut0.in_region"},  32'(bus0.in_region), 32'd0);
    chk({tag, ".dut0.frame_done"}, 32'(bus0.frame_done), 32'd0);
    chk({tag, ".dut1.address"},    bus1.address, 32'd0);
    chk({tag, ".dut1.addr_valid"}, 32'(bus1.addr_valid), 32'd0);
  endtask

  // Hand-computed values at chosen scan points.
  task automatic spot(input int frame, input int x, input int y);
    if (frame == 1 && y == 80 && x == 159) begin
      chk("lit.first_addr",  bus0.address, 32'd212992);
      chk("lit.first_valid", 32'(bus0.addr_valid), 32'd1);
      chk("lit.first_inreg", 32'(bus0.in_region), 32'd0);
    end
    if (frame == 1 && y == 80 && x == 479) begin
      chk("lit.right_valid", 32'(bus0.addr_valid), 32'd0);
      chk("lit.right_addr",  bus0.address, 32'd212992);
      chk("lit.right_inreg", 32'(bus0.in_region), 32'd1);
    end
    if (frame == 1 && y == 81 && x == 160) begin
      chk("lit.row1_addr",  bus0.address, 32'd213313);
      chk("lit.row1_valid", 32'(bus0.addr_valid), 32'd1);
    end
    if (frame == 1 && y == 2 && (x == 7 || x == 8))
      chk("lit.scale2_rep", bus1.address, 32'd213312);
    if (frame == 1 && y == 2 && x == 9)
      chk("lit.scale2_next", bus1.address, 32'd213313);
    if (frame == 1 && y == 399 && x == 478) begin
      chk("lit.last_addr", bus0.address, 32'd315391);
      chk("lit.fd_pulse",  32'(bus0.frame_done), 32'd1);
    end
    if (frame == 1 && y == 399 && x == 479)
      chk("lit.fd_cleared", 32'(bus0.frame_done), 32'd0);
    if (frame == 1 && y == 479 && x == 638) begin
      chk("lit.s2_last_addr", bus1.address, 32'd289311);
      chk("lit.s2_fd",        32'(bus1.frame_done), 32'd1);
    end
    if (frame == 2 && y == 399 && x == 478) begin
      chk("lit.post_rst_fd",    32'(bus0.frame_done), 32'd0);
      chk("lit.post_rst_valid", 32'(bus0.addr_valid), 32'd0);
    end
    if (frame == 3 && y == 79 && x == 300)
      chk("lit.pre_arm_valid", 32'(bus0.addr_valid), 32'd0);
    if (frame == 3 && y == 80 && x == 159) begin
      chk("lit.rearm_addr",  bus0.address, 32'd212992);
      chk("lit.rearm_valid", 32'(bus0.addr_valid), 32'd1);
    end
  endtask

  int xs[16] = '{0, 3, 7, 8, 9, 158, 159, 160, 161, 300, 478, 479, 480, 638, 639, 700};

  task automatic scan_frame(input int frame, input int last_line);
    for (int y = 0; y <= last_line; y++) begin
      for (int i = 0; i < 16; i++) begin
        tick(xs[i], y);
        spot(frame, xs[i], y);
        if (frame == 1 && y == 150 && xs[i] == 300) begin
          chk("lit.hold_pre", bus0.address, 32'd235533);
          pixel_en = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          chk("lit.hold_addr",  bus0.address, 32'd235533);
          chk("lit.hold_valid", 32'(bus0.addr_valid), 32'd1);
          chk("lit.hold_inreg", 32'(bus0.in_region), 32'd1);
        end
        if (frame == 2 && y == 200 && xs[i] == 300) begin
          rst_n = 1'b0;
          #1;
          all_zero("midrst");
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pixel_en = 1'b0;
    x_pixel  = '0;
    y_pixel  = '0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    scan_frame(1, 524);
    scan_frame(2, 524);
    scan_frame(3, 100);
    pixel_en = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
